icache_sa_storage: RTL and testbench
====================================

# icache_sa_storage

Set-associative, multi-word-line storage array for the instruction cache: the parametrised successor of the direct-mapped single-word store. Holds `WAYS` ways of `2^INDEX_BITS` sets, each line `WORDS_PER_LINE` words. It answers one-cycle tag lookups for the icache controller and accepts burst line fills from the memory side. Victims are chosen invalid-way-first, then by a per-set round-robin pointer.

## Interface
- `WORD_WIDTH`, 32: instruction word width.
- `WORDS_PER_LINE`, 4: words per line; power of 2, ≥2. `OFF_BITS = log2(WORDS_PER_LINE)`.
- `INDEX_BITS`, 6: set index bits.
- `WAYS`, 2: associativity; power of 2, 1..8.
- `TAG_BITS` is derived, not a parameter: `TAG_BITS = 30 - OFF_BITS - INDEX_BITS`.

Ports, clock and reset first:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `read` in 1: lookup request, one cycle per request.
- `address` in 32: CPU byte address. Fields: `[1:0]` ignored; offset `[OFF_BITS+1:2]`; index above the offset; tag in the remaining upper bits.
- `read_data` out `WORD_WIDTH`: word returned on a hit.
- `hit` out 1: lookup hit, registered.
- `miss` out 1: lookup miss, registered.
- `fill_start` in 1: begin a line fill.
- `fill_addr` in 32: address of the line to fill; offset bits ignored.
- `fill_valid` in 1: a fill beat is present.
- `fill_word` in `WORD_WIDTH`: fill beat data.
- `fill_busy` out 1: fill in progress.
- `fill_done` out 1: one-cycle pulse when the line becomes valid.
- `flush` in 1: invalidate all lines.

## Operation
- **Storage.** Per way and set: valid bit, tag, and `WORDS_PER_LINE` data words. Per set: round-robin pointer of `log2(WAYS)` bits; with `WAYS=1` the pointer is absent and way 0 is always chosen.
- **Reset.**
  - All valid bits 0.
  - All pointers 0.
  - `read_data=0`, `hit=0`, `miss=0`, `fill_busy=0`, `fill_done=0`.
  - Tag and data arrays are not cleared.
- **Lookup.** On `read`, compare the tag across all ways of the indexed set.
  - Exactly one valid matching way: `hit=1`, `read_data` = that way's word at the offset.
  - Otherwise: `miss=1`, `read_data=0`.
  - Cycles without `read`: `hit=0`, `miss=0`, `read_data` holds its previous value.
- **Fill FSM** with states IDLE and FILL.
  - IDLE + `fill_start`:
    - Latch the fill tag and index.
    - Choose the victim: the lowest-numbered invalid way; if all ways are valid, the set's pointer, which then increments modulo `WAYS`.
    - Clear the victim's valid bit and write its tag.
    - Beat counter = 0; go to FILL; `fill_busy=1`.
  - FILL + `fill_valid`:
    - Write `fill_word` to victim word [counter].
    - Counter increments.
    - On beat `WORDS_PER_LINE-1`: set valid, pulse `fill_done`, return to IDLE.
  - `fill_valid` in IDLE is ignored. `fill_start` in FILL is ignored.
- **Flush.**
  - All valid bits cleared in one cycle.
  - An active fill is aborted (back to IDLE, no `fill_done`).
  - Pointers are unchanged.
  - Flush has priority over a simultaneous `fill_start` or `fill_valid`.

## Timing
- Lookup latency is 1 cycle. `read` sampled at edge N gives `hit`/`miss`/`read_data` valid after edge N, for one cycle. Back-to-back reads are allowed every cycle.
- A lookup sees the pre-edge array state:
  - `read` on the same cycle as `fill_start`, or as the final beat, sees the old contents.
  - The filled line hits from the cycle after `fill_done` is asserted.
- While a fill is in progress the victim line is invalid, so a lookup to it misses; the other ways of that set still hit.
- Fill is `WORDS_PER_LINE` beats minimum. Gaps in `fill_valid` stall the counter. `fill_busy` is high from the edge after `fill_start` through the edge of the last beat.
- `fill_done` is high for exactly one cycle, concurrent with `fill_busy` falling.
- `reset_n` low at any time, including mid-fill, returns all state to reset values immediately.
- `miss` and `hit` are never both 1.

## Test plan
- **Fill then read.** Defaults. Fill `0x0000_1040` with beats `0xA0..0xA3`. Then read `0x1040`, `0x1044`, `0x104C`. Required: `fill_done` one cycle after the 4th beat; hits returning `0xA0`, `0xA1`, `0xA3`.
- **Cold miss.** After reset, read `0x2000`. Required: `miss=1`, `hit=0`, `read_data=0`.
- **Two ways, same set.** Fill `0x1040` (way 0) and `0x2040` (way 1); both then hit. A third fill of `0x3040` evicts way 0 (pointer was 0). Required: `0x1040` misses, `0x2040` and `0x3040` hit. A fourth fill of `0x4040` evicts way 1.
- **Read during fill.** Read `0x1040` during its fill, and on the last-beat cycle. Required: miss both times; hit on the read issued the cycle after `fill_done`.
- **Stalled fill, ignored restart.** Insert 3 idle cycles between beats 1 and 2, and pulse `fill_start` mid-fill. Required: data correct, the second start ignored, `fill_busy` high throughout.
- **Flush and reset mid-fill.** Flush during beat 2. Required: `fill_busy=0`, no `fill_done`, all earlier lines miss. Assert `reset_n` low mid-fill. Required: all outputs 0 immediately.

Source files
------------

// File: rtl/icache_sa_storage.sv
// icache_sa_storage: set-associative, multi-word-line instruction cache store.
// One-cycle registered tag lookup across all ways of a set, plus a burst
// line-fill engine with invalid-first / per-set round-robin victim choice.
module icache_sa_storage #(
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int INDEX_BITS     = 6,
  parameter int WAYS           = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  read,
  input  logic [31:0]           address,
  output logic [WORD_WIDTH-1:0] read_data,
  output logic                  hit,
  output logic                  miss,
  input  logic                  fill_start,
  input  logic [31:0]           fill_addr,
  input  logic                  fill_valid,
  input  logic [WORD_WIDTH-1:0] fill_word,
  output logic                  fill_busy,
  output logic                  fill_done,
  input  logic                  flush
);

  localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
  localparam int TAG_BITS = 30 - OFF_BITS - INDEX_BITS;
  localparam int TAG_LSB  = 2 + OFF_BITS + INDEX_BITS;
  localparam int SETS     = 1 << INDEX_BITS;
  // With a single way the pointer is a constant zero and optimises away.
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FILL} state_t;

  // Address field extraction for the lookup and fill ports.
  logic [OFF_BITS-1:0]   rd_off;
  logic [INDEX_BITS-1:0] rd_index;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [INDEX_BITS-1:0] start_index;
  logic [TAG_BITS-1:0]   start_tag;

  assign rd_off      = address[OFF_BITS+1:2];
  assign rd_index    = address[TAG_LSB-1:OFF_BITS+2];
  assign rd_tag      = address[31:TAG_LSB];
  assign start_index = fill_addr[TAG_LSB-1:OFF_BITS+2];
  assign start_tag   = fill_addr[31:TAG_LSB];

  // Byte-offset bits and the fill line offset carry no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[1:0], fill_addr[OFF_BITS+1:0]};

  // Per-set state that must come out of reset clean.
  logic [WAYS-1:0]     valid_reg [SETS];
  logic [WAY_BITS-1:0] ptr_reg   [SETS];

  // Fill engine state.
  state_t                state_reg, state_next;
  logic [OFF_BITS-1:0]   beat_reg;
  logic [WAY_BITS-1:0]   victim_reg;
  logic [INDEX_BITS-1:0] fill_index_reg;

  logic                start_fill;
  logic                beat_write;
  logic                last_beat;
  logic [WAY_BITS-1:0] victim_sel;
  logic                all_valid;

  // Lookup datapath.
  logic [WAYS-1:0]       match;
  logic [WORD_WIDTH-1:0] way_word [WAYS];
  logic [WORD_WIDTH-1:0] hit_word;
  logic                  one_hit;

  // Tag and data arrays per way; not reset, validity is tracked separately.
  // The tag is written on the start cycle, so it need not be held afterwards.
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TAG_BITS-1:0]   tag_mem  [SETS];
      logic [WORD_WIDTH-1:0] data_mem [SETS*WORDS_PER_LINE];

      // Array writes: tag when the fill starts, one data word per beat.
      always_ff @(posedge clk) begin
        if (start_fill && (victim_sel == WAY_BITS'(gi)))
          tag_mem[start_index] <= start_tag;
        if (beat_write && (victim_reg == WAY_BITS'(gi)))
          data_mem[{fill_index_reg, beat_reg}] <= fill_word;
      end

      assign match[gi]    = valid_reg[rd_index][gi] && (tag_mem[rd_index] == rd_tag);
      assign way_word[gi] = data_mem[{rd_index, rd_off}];
    end
  endgenerate

  // Merge the matching way's word; only meaningful when exactly one matches.
  always_comb begin
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (match[w]) hit_word = hit_word | way_word[w];
    end
  end

  // A duplicate tag in two ways is treated as a miss rather than a blend.
  assign one_hit = (match != '0) && ((match & (match - WAYS'(1))) == '0);

  // Victim choice: lowest invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    victim_sel = ptr_reg[start_index];
    all_valid  = &valid_reg[start_index];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_reg[start_index][w]) victim_sel = WAY_BITS'(w);
    end
  end

  // Fill FSM next-state and strobes; flush overrides any fill activity.
  always_comb begin
    state_next = state_reg;
    start_fill = 1'b0;
    beat_write = 1'b0;
    last_beat  = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (fill_start) begin
            start_fill = 1'b1;
            state_next = FILL;
          end
        end
        FILL: begin
          if (fill_valid) begin
            beat_write = 1'b1;
            if (beat_reg == OFF_BITS'(WORDS_PER_LINE - 1)) begin
              last_beat  = 1'b1;
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Fill FSM state register, beat counter and latched fill target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      beat_reg       <= '0;
      victim_reg     <= '0;
      fill_index_reg <= '0;
      fill_done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      fill_done <= last_beat;
      if (start_fill) begin
        fill_index_reg <= start_index;
        victim_reg     <= victim_sel;
        beat_reg       <= '0;
      end else if (beat_write) begin
        beat_reg <= beat_reg + 1'b1;
      end
    end
  end

  assign fill_busy = (state_reg == FILL);

  // Valid bits and round-robin pointers; the victim stays invalid while filling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        ptr_reg[s]   <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) valid_reg[s] <= '0;
    end else begin
      if (start_fill) begin
        valid_reg[start_index][victim_sel] <= 1'b0;
        if (all_valid && (WAYS > 1))
          ptr_reg[start_index] <= ptr_reg[start_index] + 1'b1;
      end
      if (last_beat)
        valid_reg[fill_index_reg][victim_reg] <= 1'b1;
    end
  end

  // Registered lookup result; read_data holds between requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit       <= 1'b0;
      miss      <= 1'b0;
      read_data <= '0;
    end else if (read) begin
      hit       <= one_hit;
      miss      <= !one_hit;
      read_data <= one_hit ? hit_word : '0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
    end
  end

endmodule

// File: tb/tb_icache_sa_storage.sv
// tb_icache_sa_storage: directed scenarios with hand-computed expectations
// for the set-associative icache store (default parameters: 2 ways, 4 words).
module tb_icache_sa_storage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        read = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] read_data;
  logic        hit;
  logic        miss;
  logic        fill_start = 1'b0;
  logic [31:0] fill_addr = '0;
  logic        fill_valid = 1'b0;
  logic [31:0] fill_word = '0;
  logic        fill_busy;
  logic        fill_done;
  logic        flush = 1'b0;

  int vec_count = 0;
  int err_count = 0;

  icache_sa_storage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .read       (read),
    .address    (address),
    .read_data  (read_data),
    .hit        (hit),
    .miss       (miss),
    .fill_start (fill_start),
    .fill_addr  (fill_addr),
    .fill_valid (fill_valid),
    .fill_word  (fill_word),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; read = 1'b0; fill_start = 1'b0; fill_valid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic do_read(input logic [31:0] a, output logic h, output logic m, output logic [31:0] d);
    read = 1'b1; address = a;
    tick();
    h = hit; m = miss; d = read_data;
    read = 1'b0;
    $display("read  %08h -> hit=%0b miss=%0b data=%08h", a, h, m, d);
  endtask

  // Start plus four back-to-back beats; reports observed handshake flags.
  task automatic fill_line(input logic [31:0] a, input logic [31:0] base,
                           output logic busy_seen, output logic early_done, output logic done_seen);
    fill_start = 1'b1; fill_addr = a;
    tick();
    fill_start = 1'b0;
    busy_seen  = fill_busy;
    early_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fill_valid = 1'b1; fill_word = base + i;
      tick();
      if (i < 3) early_done = early_done | fill_done;
    end
    done_seen  = fill_done && !fill_busy;
    fill_valid = 1'b0;
    $display("fill  %08h base=%08h busy=%0b done=%0b", a, base, busy_seen, done_seen);
  endtask

  task automatic test_reset();
    do_reset();
    vec_count++; if (hit !== 1'b0) begin err_count++; $display("FAIL reset_hit: got %0b want 0", hit); end
    vec_count++; if (miss !== 1'b0) begin err_count++; $display("FAIL reset_miss: got %0b want 0", miss); end
    vec_count++; if (read_data !== 32'h0) begin err_count++; $display("FAIL reset_data: got %08h want 0", read_data); end
    vec_count++; if (fill_busy !== 1'b0) begin err_count++; $display("FAIL reset_busy: got %0b want 0", fill_busy); end
    vec_count++; if (fill_done !== 1'b0) begin err_count++; $display("FAIL reset_done: got %0b want 0", fill_done); end
  endtask

  task automatic test_cold_miss();
    logic h, m; logic [31:0] d;
    do_reset();
    do_read(32'h2000, h, m, d);
    vec_count++; if (m !== 1'b1) begin err_count++; $display("FAIL cold_miss: got %0b want 1", m); end
    vec_count++; if (h !== 1'b0) begin err_count++; $display("FAIL cold_hit: got %0b want 0", h); end
    vec_count++; if (d !== 32'h0) begin err_count++; $display("FAIL cold_data: got %08h want 0", d); end
  endtask

  task automatic test_fill_then_read();
    logic b, e, dn, h, m; logic [31:0] d;
    do_reset();
    fill_line(32'h1040, 32'hA0, b, e, dn);
    vec_count++; if (b !== 1'b1) begin err_count++; $display("FAIL ftr_busy: got %0b want 1", b); end
    vec_count++; if (e !== 1'b0) begin err_count++; $display("FAIL ftr_early_done: got %0b want 0", e); end
    vec_count++; if (dn !== 1'b1) begin err_count++; $display("FAIL ftr_done: got %0b want 1", dn); end
    read = 1'b1; address = 32'h1040;
    tick();
    vec_count++; if (fill_done !== 1'b0) begin err_count++; $display("FAIL ftr_done_pulse: got %0b want 0", fill_done); end
    vec_count++; if (hit !== 1'b1 || read_data !== 32'hA0) begin err_count++; $display("FAIL ftr_rd0: got hit=%0b %08h want 1 000000a0", hit, read_data); end
    do_read(32'h1044, h, m, d);
    vec_count++; if (h !== 1'b1 || m !== 1'b0 || d !== 32'hA1) begin err_count++; $display("FAIL ftr_rd1: got hit=%0b miss=%0b %08h want 1 0 000000a1", h, m, d); end
    do_read(32'h104C, h, m, d);
    vec_count++; if (h !== 1'b1 || d !== 32'hA3) begin err_count++; $display("FAIL ftr_rd3: got hit=%0b %08h want 1 000000a3", h, d); end
    tick();
    vec_count++; if (hit !== 1'b0 || miss !== 1'b0 || read_data !== 32'hA3) begin err_count++; $display("FAIL ftr_idle_hold: got hit=%0b miss=%0b %08h want 0 0 000000a3", hit, miss, read_data); end
  endtask

  task automatic test_two_ways();
    logic b, e, dn, h, m; logic [31:0] d;
    do_reset();
    fill_line(32'h1040, 32'h10, b, e, dn);
    fill_line(32'h2040, 32'h20, b, e, dn);
    do_read(32'h1040, h, m, d);
    vec_count++; if (h !== 1'b1 || d !== 32'h10) begin err_count++; $display("FAIL tw_a_hit: got hit=%0b %08h want 1 00000010", h, d); end
    do_read(32'h2044, h, m, d);
    vec_count++; if (h !== 1'b1 || d !== 32'h21) begin err_count++; $display("FAIL tw_b_hit: got hit=%0b %08h want 1 00000021", h, d); end
    fill_line(32'h3040, 32'h30, b, e, dn);
    do_read(32'h1040, h, m, d);
    vec_count++; if (m !== 1'b1 || h !== 1'b0) begin err_count++; $display("FAIL tw_a_evicted: got miss=%0b hit=%0b want 1 0", m, h); end
    do_read(32'h2040, h, m, d);
    vec_count++; if (h !== 1'b1 || d !== 32'h20) begin err_count++; $display("FAIL tw_b_kept: got hit=%0b %08h want 1 00000020", h, d); end
    do_read(32'h3048, h, m, d);
    vec_count++; if (h !== 1'b1 || d !== 32'h32) begin err_count++; $display("FAIL tw_c_hit: got hit=%0b %08h want 1 00000032", h, d); end
    fill_line(32'h4040, 32'h40, b, e, dn);
    do_read(32'h2040, h, m, d);
    vec_count++; if (m !== 1'b1) begin err_count++; $display("FAIL tw_b_evicted: got miss=%0b want 1", m); end
    do_read(32'h3040, h, m, d);
    vec_count++; if (h !== 1'b1 || d !== 32'h30) begin err_count++; $display("FAIL tw_c_kept: got hit=%0b %08h want 1 00000030", h, d); end
    do_read(32'h404C, h, m, d);
    vec_count++; if (h !== 1'b1 || d !== 32'h43) begin err_count++; $display("FAIL tw_d_hit: got hit=%0b %08h want 1 00000043", h, d); end
  endtask

  task automatic test_read_during_fill();
    logic b, e, dn;
    do_reset();
    fill_line(32'h2040, 32'h50, b, e, dn);
    fill_start = 1'b1; fill_addr = 32'h1040; read = 1'b1; address = 32'h2040;
    tick();
    fill_start = 1'b0;
    vec_count++; if (hit !== 1'b1 || read_data !== 32'h50) begin err_count++; $display("FAIL rdf_start_cycle: got hit=%0b %08h want 1 00000050", hit, read_data); end
    fill_valid = 1'b1; fill_word = 32'h60; address = 32'h1040;
    tick();
    vec_count++; if (miss !== 1'b1 || hit !== 1'b0) begin err_count++; $display("FAIL rdf_mid_miss: got miss=%0b hit=%0b want 1 0", miss, hit); end
    fill_word = 32'h61; address = 32'h2044;
    tick();
    vec_count++; if (hit !== 1'b1 || read_data !== 32'h51) begin err_count++; $display("FAIL rdf_other_way: got hit=%0b %08h want 1 00000051", hit, read_data); end
    fill_word = 32'h62; read = 1'b0;
    tick();
    fill_word = 32'h63; read = 1'b1; address = 32'h1040;
    tick();
    vec_count++; if (miss !== 1'b1 || hit !== 1'b0) begin err_count++; $display("FAIL rdf_last_beat_miss: got miss=%0b hit=%0b want 1 0", miss, hit); end
    vec_count++; if (fill_done !== 1'b1 || fill_busy !== 1'b0) begin err_count++; $display("FAIL rdf_done: got done=%0b busy=%0b want 1 0", fill_done, fill_busy); end
    fill_valid = 1'b0; address = 32'h1044;
    tick();
    read = 1'b0;
    vec_count++; if (hit !== 1'b1 || read_data !== 32'h61) begin err_count++; $display("FAIL rdf_after_done: got hit=%0b %08h want 1 00000061", hit, read_data); end
  endtask

  task automatic test_stall_restart();
    logic h, m; logic [31:0] d; logic busy_all, done_any;
    do_reset();
    busy_all = 1'b1; done_any = 1'b0;
    fill_start = 1'b1; fill_addr = 32'h5080;
    tick();
    fill_start = 1'b0;
    busy_all = busy_all & fill_busy;
    for (int i = 0; i < 2; i++) begin
      fill_valid = 1'b1; fill_word = 32'h70 + i;
      tick();
      busy_all = busy_all & fill_busy; done_any = done_any | fill_done;
    end
    fill_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fill_start = (i == 1); fill_addr = 32'h6080;
      tick();
      busy_all = busy_all & fill_busy; done_any = done_any | fill_done;
    end
    fill_start = 1'b0;
    fill_valid = 1'b1; fill_word = 32'h72;
    tick();
    busy_all = busy_all & fill_busy; done_any = done_any | fill_done;
    fill_word = 32'h73;
    tick();
    fill_valid = 1'b0;
    vec_count++; if (busy_all !== 1'b1) begin err_count++; $display("FAIL stall_busy: got %0b want 1", busy_all); end
    vec_count++; if (done_any !== 1'b0) begin err_count++; $display("FAIL stall_early_done: got %0b want 0", done_any); end
    vec_count++; if (fill_done !== 1'b1 || fill_busy !== 1'b0) begin err_count++; $display("FAIL stall_done: got done=%0b busy=%0b want 1 0", fill_done, fill_busy); end
    do_read(32'h5084, h, m, d);
    vec_count++; if (h !== 1'b1 || d !== 32'h71) begin err_count++; $display("FAIL stall_rd1: got hit=%0b %08h want 1 00000071", h, d); end
    do_read(32'h5088, h, m, d);
    vec_count++; if (h !== 1'b1 || d !== 32'h72) begin err_count++; $display("FAIL stall_rd2: got hit=%0b %08h want 1 00000072", h, d); end
    do_read(32'h508C, h, m, d);
    vec_count++; if (h !== 1'b1 || d !== 32'h73) begin err_count++; $display("FAIL stall_rd3: got hit=%0b %08h want 1 00000073", h, d); end
    do_read(32'h6080, h, m, d);
    vec_count++; if (m !== 1'b1) begin err_count++; $display("FAIL stall_restart_ignored: got miss=%0b want 1", m); end
  endtask

  task automatic test_flush_reset();
    logic b, e, dn, h, m; logic [31:0] d;
    do_reset();
    fill_line(32'h1040, 32'hA0, b, e, dn);
    fill_line(32'h2040, 32'hB0, b, e, dn);
    fill_start = 1'b1; fill_addr = 32'h3040;
    tick();
    fill_start = 1'b0;
    fill_valid = 1'b1; fill_word = 32'hC0;
    tick();
    fill_word = 32'hC1;
    tick();
    fill_word = 32'hC2; flush = 1'b1;
    tick();
    flush = 1'b0;
    vec_count++; if (fill_busy !== 1'b0 || fill_done !== 1'b0) begin err_count++; $display("FAIL flush_abort: got busy=%0b done=%0b want 0 0", fill_busy, fill_done); end
    fill_word = 32'hC3;
    tick();
    fill_valid = 1'b0;
    vec_count++; if (fill_done !== 1'b0) begin err_count++; $display("FAIL flush_no_done: got %0b want 0", fill_done); end
    do_read(32'h2040, h, m, d);
    vec_count++; if (m !== 1'b1) begin err_count++; $display("FAIL flush_b_miss: got miss=%0b want 1", m); end
    do_read(32'h1040, h, m, d);
    vec_count++; if (m !== 1'b1) begin err_count++; $display("FAIL flush_a_miss: got miss=%0b want 1", m); end
    do_read(32'h3040, h, m, d);
    vec_count++; if (m !== 1'b1) begin err_count++; $display("FAIL flush_c_miss: got miss=%0b want 1", m); end
    // Flush wins over a simultaneous fill_start.
    fill_start = 1'b1; fill_addr = 32'h1040; flush = 1'b1;
    tick();
    fill_start = 1'b0; flush = 1'b0;
    vec_count++; if (fill_busy !== 1'b0) begin err_count++; $display("FAIL flush_prio: got busy=%0b want 0", fill_busy); end
    // Reset mid-fill while a hit is on the outputs.
    fill_line(32'h2040, 32'h80, b, e, dn);
    fill_start = 1'b1; fill_addr = 32'h7000; read = 1'b1; address = 32'h2040;
    tick();
    vec_count++; if (hit !== 1'b1 || read_data !== 32'h80 || fill_busy !== 1'b1) begin err_count++; $display("FAIL prereset: got hit=%0b %08h busy=%0b want 1 00000080 1", hit, read_data, fill_busy); end
    reset_n = 1'b0; fill_start = 1'b0; read = 1'b0;
    #2;
    vec_count++; if (hit !== 1'b0 || miss !== 1'b0 || read_data !== 32'h0 || fill_busy !== 1'b0 || fill_done !== 1'b0)
      begin err_count++; $display("FAIL async_reset: got hit=%0b miss=%0b %08h busy=%0b done=%0b want all 0", hit, miss, read_data, fill_busy, fill_done); end
    tick();
    reset_n = 1'b1;
    do_read(32'h2040, h, m, d);
    vec_count++; if (m !== 1'b1 || h !== 1'b0) begin err_count++; $display("FAIL postreset_miss: got miss=%0b hit=%0b want 1 0", m, h); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_fill_then_read();
    test_two_ways();
    test_read_during_fill();
    test_stall_restart();
    test_flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
